// File: rtl/pipeline_scoreboard.sv
// Hazard/forwarding controller for the in-order pipeline.
// Tracks in-flight instructions from Execute (stage 1) to Write Back
// (stage STAGES) and derives forwarding selects, load-use stalls,
// branch flushes and the Execute hold for the multicycle unit.
//
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-low reset
//   issue*              - Decode-stage instruction fields
//   takeBranch          - branch resolved taken in Execute
//   stall               - hold PC and Fetch/Decode register
//   flushD              - clear the Fetch/Decode register
//   flushE              - load a bubble into the Decode/Execute register
//   holdE               - keep Decode/Execute contents (downstream gets a bubble)
//   fwdSel1, fwdSel2    - Execute operand source: 0 = regfile, k = stage k+1
//   multiDone           - last Execute cycle of a multicycle instruction
module pipeline_scoreboard #(
  parameter int unsigned ADDRESSWIDTH = 4,
  parameter int unsigned STAGES       = 3,
  parameter int unsigned MULCYCLES    = 4,
  parameter int unsigned SELWIDTH     = $clog2(STAGES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issueValid,
  input  logic                    issueWriteEnable,
  input  logic [ADDRESSWIDTH-1:0] issueDest,
  input  logic [ADDRESSWIDTH-1:0] issueSrc1,
  input  logic [ADDRESSWIDTH-1:0] issueSrc2,
  input  logic                    issueUse1,
  input  logic                    issueUse2,
  input  logic                    issueIsLoad,
  input  logic                    issueIsMulti,
  input  logic                    takeBranch,
  output logic                    stall,
  output logic                    flushD,
  output logic                    flushE,
  output logic                    holdE,
  output logic [SELWIDTH-1:0]     fwdSel1,
  output logic [SELWIDTH-1:0]     fwdSel2,
  output logic                    multiDone
);

  // Counter only needs to reach MULCYCLES-1.
  localparam int unsigned COUNTWIDTH = (MULCYCLES > 1) ? $clog2(MULCYCLES) : 1;

  typedef struct packed {
    logic                    valid;
    logic                    writeEnable;
    logic [ADDRESSWIDTH-1:0] dest;
    logic                    isLoad;
    logic                    isMulti;
    logic [ADDRESSWIDTH-1:0] src1;
    logic [ADDRESSWIDTH-1:0] src2;
    logic                    use1;
    logic                    use2;
  } entryT;

  entryT                 stageQ [1:STAGES];
  entryT                 stageD [1:STAGES];
  entryT                 issueEntry;
  logic [COUNTWIDTH-1:0] multiCountQ;
  logic [COUNTWIDTH-1:0] multiCountD;
  logic                  busy;
  logic                  branch;
  logic                  loadUse;
  logic                  srcHitsLoad;

  // Pack the Decode instruction into a pipeline entry.
  always_comb begin
    issueEntry             = '0;
    issueEntry.valid       = 1'b1;
    issueEntry.writeEnable = issueWriteEnable;
    issueEntry.dest        = issueDest;
    issueEntry.isLoad      = issueIsLoad;
    issueEntry.isMulti     = issueIsMulti;
    issueEntry.src1        = issueSrc1;
    issueEntry.src2        = issueSrc2;
    issueEntry.use1        = issueUse1;
    issueEntry.use2        = issueUse2;
  end

  // Hazard conditions; all forced low while reset is asserted.
  always_comb begin
    srcHitsLoad = (issueUse1 && (issueSrc1 == stageQ[1].dest)) ||
                  (issueUse2 && (issueSrc2 == stageQ[1].dest));
    busy    = reset && stageQ[1].valid && stageQ[1].isMulti &&
              (32'(multiCountQ) < (MULCYCLES - 32'd1));
    branch  = reset && takeBranch && stageQ[1].valid && !stageQ[1].isMulti;
    loadUse = reset && issueValid && stageQ[1].valid && stageQ[1].isLoad &&
              stageQ[1].writeEnable && srcHitsLoad;
  end

  // Control outputs; branch outranks loadUse, busy outranks both stall sources.
  always_comb begin
    stall     = busy || loadUse;
    flushD    = branch;
    flushE    = branch || (loadUse && !busy);
    holdE     = busy;
    multiDone = reset && stageQ[1].valid && stageQ[1].isMulti && !busy;
  end

  // Forwarding: scan oldest to youngest so the lowest matching stage wins.
  always_comb begin
    fwdSel1 = '0;
    fwdSel2 = '0;
    if (reset) begin
      for (int k = int'(STAGES); k >= 2; k--) begin
        if (stageQ[k].valid && stageQ[k].writeEnable) begin
          if (stageQ[1].use1 && (stageQ[k].dest == stageQ[1].src1)) fwdSel1 = SELWIDTH'(k - 1);
          if (stageQ[1].use2 && (stageQ[k].dest == stageQ[1].src2)) fwdSel2 = SELWIDTH'(k - 1);
        end
      end
    end
  end

  // Next-state: default is a full shift with a bubble entering stage 1.
  always_comb begin
    multiCountD = '0;
    stageD[1]   = '0;
    for (int k = 2; k <= int'(STAGES); k++) begin
      stageD[k] = stageQ[k - 1];
    end
    if (branch) begin
      stageD[1] = '0;
    end else if (busy) begin
      // Execute holds; only a bubble leaves it.
      stageD[1]   = stageQ[1];
      stageD[2]   = '0;
      multiCountD = multiCountQ + COUNTWIDTH'(1);
    end else if (loadUse) begin
      stageD[1] = '0;
    end else if (issueValid) begin
      stageD[1] = issueEntry;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 1; k <= int'(STAGES); k++) begin
        stageQ[k] <= '0;
      end
      multiCountQ <= '0;
    end else begin
      for (int k = 1; k <= int'(STAGES); k++) begin
        stageQ[k] <= stageD[k];
      end
      multiCountQ <= multiCountD;
    end
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: directed scenarios plus
// randomized traffic, compared against a queue-style instruction model.
module tb_pipeline_scoreboard;

  localparam int AW = 4;
  localparam int S  = 3;
  localparam int MC = 4;
  localparam int SW = $clog2(S);

  logic          clock = 1'b0;
  logic          reset;
  logic          issueValid, issueWriteEnable, issueUse1, issueUse2;
  logic          issueIsLoad, issueIsMulti, takeBranch;
  logic [AW-1:0] issueDest, issueSrc1, issueSrc2;
  logic          stall, flushD, flushE, holdE, multiDone;
  logic [SW-1:0] fwdSel1, fwdSel2;

  int errors = 0;
  int checks = 0;

  pipeline_scoreboard #(
    .ADDRESSWIDTH(AW), .STAGES(S), .MULCYCLES(MC), .SELWIDTH(SW)
  ) dut (
    .clock(clock), .reset(reset),
    .issueValid(issueValid), .issueWriteEnable(issueWriteEnable),
    .issueDest(issueDest), .issueSrc1(issueSrc1), .issueSrc2(issueSrc2),
    .issueUse1(issueUse1), .issueUse2(issueUse2),
    .issueIsLoad(issueIsLoad), .issueIsMulti(issueIsMulti),
    .takeBranch(takeBranch),
    .stall(stall), .flushD(flushD), .flushE(flushE), .holdE(holdE),
    .fwdSel1(fwdSel1), .fwdSel2(fwdSel2), .multiDone(multiDone)
  );

  always #5 clock = ~clock;

  // Reference model: one instruction record per pipeline position, plus the
  // number of Execute cycles the instruction in Execute still owes.
  typedef struct {
    bit valid;
    bit we;
    int dest;
    int src1;
    int src2;
    bit use1;
    bit use2;
    bit isLoad;
    bit isMulti;
  } instT;

  instT pipe [1:S];
  int   multiLeft;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic instT bubble();
    instT b;
    b = '{default: 0};
    return b;
  endfunction

  // Youngest in-flight producer of src, as 0 (regfile) or stage-1.
  function automatic int fwdOf(input int src, input bit wanted);
    if (!wanted) return 0;
    for (int k = 2; k <= S; k++)
      if (pipe[k].valid && pipe[k].we && pipe[k].dest == src) return k - 1;
    return 0;
  endfunction

  function automatic bit mBusy();
    return reset && pipe[1].valid && pipe[1].isMulti && multiLeft > 0;
  endfunction

  function automatic bit mBranch();
    return reset && takeBranch && pipe[1].valid && !pipe[1].isMulti;
  endfunction

  function automatic bit mLoadUse();
    return reset && issueValid && pipe[1].valid && pipe[1].isLoad && pipe[1].we &&
           ((issueUse1 && int'(issueSrc1) == pipe[1].dest) ||
            (issueUse2 && int'(issueSrc2) == pipe[1].dest));
  endfunction

  task automatic sampleAndCheck(input string tag);
    bit bz, br, lu;
    @(negedge clock);
    bz = mBusy();
    br = mBranch();
    lu = mLoadUse();
    checkEq({tag, ".stall"},  32'(stall),  32'(bz || lu));
    checkEq({tag, ".flushD"}, 32'(flushD), 32'(br));
    checkEq({tag, ".flushE"}, 32'(flushE), 32'(br || (lu && !bz)));
    checkEq({tag, ".holdE"},  32'(holdE),  32'(bz));
    checkEq({tag, ".multiDone"}, 32'(multiDone),
            32'(reset && pipe[1].valid && pipe[1].isMulti && !bz));
    checkEq({tag, ".fwdSel1"}, 32'(fwdSel1),
            32'(reset ? fwdOf(pipe[1].src1, pipe[1].valid && pipe[1].use1) : 0));
    checkEq({tag, ".fwdSel2"}, 32'(fwdSel2),
            32'(reset ? fwdOf(pipe[1].src2, pipe[1].valid && pipe[1].use2) : 0));
  endtask

  // Clock edge plus model update using the inputs held through the edge.
  task automatic advance();
    bit bz, br, lu;
    instT n;
    bz = mBusy();
    br = mBranch();
    lu = mLoadUse();
    @(posedge clock);
    if (!reset) begin
      for (int k = 1; k <= S; k++) pipe[k] = bubble();
      multiLeft = 0;
    end else if (bz) begin
      for (int k = S; k >= 3; k--) pipe[k] = pipe[k-1];
      pipe[2] = bubble();
      multiLeft--;
    end else begin
      for (int k = S; k >= 2; k--) pipe[k] = pipe[k-1];
      if (!br && !lu && issueValid) begin
        n = '{valid: 1, we: issueWriteEnable, dest: int'(issueDest),
              src1: int'(issueSrc1), src2: int'(issueSrc2), use1: issueUse1,
              use2: issueUse2, isLoad: issueIsLoad, isMulti: issueIsMulti};
        pipe[1]   = n;
        multiLeft = issueIsMulti ? MC - 1 : 0;
      end else begin
        pipe[1]   = bubble();
        multiLeft = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit we, input int d, input int s1, input int s2,
                       input bit u1, input bit u2, input bit ld, input bit mul, input bit br);
    issueValid       = v;
    issueWriteEnable = we;
    issueDest        = AW'(d);
    issueSrc1        = AW'(s1);
    issueSrc2        = AW'(s2);
    issueUse1        = u1;
    issueUse2        = u2;
    issueIsLoad      = ld;
    issueIsMulti     = mul;
    takeBranch       = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    idle();
    reset = 1'b0;
    advance();
    advance();
    reset = 1'b1;
  endtask

  initial begin
    for (int k = 1; k <= S; k++) pipe[k] = bubble();
    multiLeft = 0;
    reset = 1'b0;
    idle();
    @(posedge clock);
    #1;
    doReset();

    // Reset state
    sampleAndCheck("rst");
    checkEq("rst.stall", 32'(stall), 0);
    checkEq("rst.fwd1", 32'(fwdSel1), 0);
    idle();

    // Back-to-back ALU dependency
    drive(1, 1, 3, 1, 2, 1, 1, 0, 0, 0); sampleAndCheck("alu0"); advance();
    drive(1, 1, 4, 3, 3, 1, 1, 0, 0, 0); sampleAndCheck("alu1"); advance();
    drive(1, 1, 5, 3, 0, 1, 1, 0, 0, 0); sampleAndCheck("alu2");
    checkEq("alu.fwd1_mem", 32'(fwdSel1), 1);
    checkEq("alu.fwd2_mem", 32'(fwdSel2), 1);
    advance();
    idle(); sampleAndCheck("alu3");
    checkEq("alu.fwd1_wb", 32'(fwdSel1), 2);
    checkEq("alu.fwd2_r0", 32'(fwdSel2), 0);
    checkEq("alu.nostall", 32'(stall), 0);
    advance();

    // Load-use
    doReset();
    drive(1, 1, 5, 0, 0, 0, 0, 1, 0, 0); sampleAndCheck("ld0"); advance();
    drive(1, 1, 6, 5, 0, 1, 1, 0, 0, 0); sampleAndCheck("ld1");
    checkEq("ld.stall", 32'(stall), 1);
    checkEq("ld.flushE", 32'(flushE), 1);
    advance();
    sampleAndCheck("ld2");
    checkEq("ld.stall_once", 32'(stall), 0);
    advance();
    idle(); sampleAndCheck("ld3");
    checkEq("ld.fwd1_wb", 32'(fwdSel1), 2);
    advance();

    // Taken branch in Execute
    doReset();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); sampleAndCheck("br0"); advance();
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 1); sampleAndCheck("br1");
    checkEq("br.flushD", 32'(flushD), 1);
    checkEq("br.flushE", 32'(flushE), 1);
    checkEq("br.stall", 32'(stall), 0);
    advance();
    drive(1, 1, 2, 9, 0, 1, 0, 0, 0, 0); sampleAndCheck("br2");
    checkEq("br.flushD_once", 32'(flushD), 0);
    advance();
    idle(); sampleAndCheck("br3");
    checkEq("br.discarded", 32'(fwdSel1), 0);
    advance();

    // Multicycle
    doReset();
    drive(1, 1, 7, 0, 0, 0, 0, 0, 1, 0); sampleAndCheck("mc0"); advance();
    drive(1, 1, 8, 7, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sampleAndCheck("mcHold");
      checkEq("mc.holdE", 32'(holdE), 1);
      checkEq("mc.stall", 32'(stall), 1);
      checkEq("mc.notDone", 32'(multiDone), 0);
      advance();
    end
    sampleAndCheck("mc4");
    checkEq("mc.done", 32'(multiDone), 1);
    checkEq("mc.release", 32'(holdE), 0);
    advance();
    idle(); sampleAndCheck("mc5");
    checkEq("mc.fwd1", 32'(fwdSel1), 1);
    advance();

    // Youngest-match priority and use gating
    doReset();
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); sampleAndCheck("ym0"); advance();
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); sampleAndCheck("ym1"); advance();
    drive(1, 1, 4, 2, 2, 1, 0, 0, 0, 0); sampleAndCheck("ym2"); advance();
    idle(); sampleAndCheck("ym3");
    checkEq("ym.youngest", 32'(fwdSel1), 1);
    checkEq("ym.unused", 32'(fwdSel2), 0);
    advance();

    // Reset mid-hold
    doReset();
    drive(1, 1, 7, 0, 0, 0, 0, 0, 1, 0); sampleAndCheck("rh0"); advance();
    idle(); sampleAndCheck("rh1");
    checkEq("rh.hold1", 32'(holdE), 1);
    advance();
    reset = 1'b0; sampleAndCheck("rh2"); advance();
    reset = 1'b1;
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); sampleAndCheck("rh3");
    checkEq("rh.holdE", 32'(holdE), 0);
    checkEq("rh.stall", 32'(stall), 0);
    checkEq("rh.multiDone", 32'(multiDone), 0);
    advance();
    drive(1, 1, 4, 3, 0, 1, 0, 0, 0, 0); sampleAndCheck("rh4"); advance();
    idle(); sampleAndCheck("rh5");
    checkEq("rh.resumed", 32'(fwdSel1), 1);
    advance();

    // Randomized traffic on a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      drive($urandom_range(99) < 80, $urandom_range(99) < 85,
            int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
            $urandom_range(99) < 70, $urandom_range(99) < 60,
            $urandom_range(99) < 25, $urandom_range(99) < 12,
            $urandom_range(99) < 15);
      sampleAndCheck("rnd");
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
